// File: rtl/softmax_norm.sv
// softmax_norm: buffers one row of e^x values, sums them, then divides each
// entry by the row sum with a bit-serial restoring divider and streams the
// normalized probabilities out with a valid/ready handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// COLLECT  | accepting ex_in into the row buffer and accumulating the sum
// DIVIDE   | computing one quotient bit per cycle for entry r_idx
// EMIT     | holding p_out/p_last/p_vld until the consumer takes the entry
module softmax_norm #(
    parameter int ROW_LEN    = 4,
    parameter int DIV_CYCLES = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] ex_in,
    input  logic       ex_vld,
    output logic       ex_rdy,
    output logic [7:0] p_out,
    output logic       p_vld,
    input  logic       p_rdy,
    output logic       p_last
);

    localparam int IDX_W = $clog2(ROW_LEN);
    localparam int SUM_W = 9 + IDX_W;
    // Partial remainder is always below 2*sum, so one extra bit suffices.
    localparam int REM_W = SUM_W + 1;
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DIVIDE  = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [SUM_W-1:0]      r_sum;
    logic [CNT_W-1:0]      r_iter;
    logic [REM_W-1:0]      r_rem;
    logic [DIV_CYCLES-1:0] r_quo;
    logic [7:0]            r_p_out;
    logic                  r_p_vld;
    logic                  r_p_last;
    logic [8:0]            r_buf [ROW_LEN];

    logic [8:0]            w_ent;
    logic [REM_W-1:0]      w_rem_in;
    logic                  w_ge;
    logic [REM_W-1:0]      w_rem_sub;
    logic [REM_W-1:0]      w_rem_nxt;
    logic [DIV_CYCLES-1:0] w_quo;
    logic [7:0]            w_p;
    logic                  w_ex_xfer;

    assign ex_rdy    = (r_state == S_COLLECT);
    assign w_ex_xfer = ex_vld && ex_rdy;
    assign p_out     = r_p_out;
    assign p_vld     = r_p_vld;
    assign p_last    = r_p_last;

    // Fractional long division: the entry itself is the first partial
    // remainder (entry <= sum, so the first quotient bit has weight 256);
    // each step compares against sum, subtracts when it fits, then doubles.
    assign w_ent     = r_buf[r_idx];
    assign w_rem_in  = (r_iter == '0) ? REM_W'(w_ent) : r_rem;
    assign w_ge      = (w_rem_in >= REM_W'(r_sum));
    assign w_rem_sub = w_ge ? (w_rem_in - REM_W'(r_sum)) : w_rem_in;
    assign w_rem_nxt = w_rem_sub << 1;
    assign w_quo     = {r_quo[DIV_CYCLES-2:0], w_ge};

    // Saturate to UQ0.8; an all-zero row forces zero instead of the
    // all-ones quotient a divide by zero would produce.
    always_comb begin
        w_p = 8'd0;
        if (r_sum != '0) begin
            if (|w_quo[DIV_CYCLES-1:8]) w_p = 8'hFF;
            else                        w_p = w_quo[7:0];
        end
    end

    // Row buffer write; contents need no reset since every entry is written
    // before it is read.
    always_ff @(posedge clk) begin
        if (w_ex_xfer) r_buf[r_idx] <= ex_in;
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_COLLECT;
            r_idx    <= '0;
            r_sum    <= '0;
            r_iter   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_p_out  <= 8'd0;
            r_p_vld  <= 1'b0;
            r_p_last <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (ex_vld) begin
                        r_sum <= r_sum + SUM_W'(ex_in);
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_iter  <= '0;
                            r_rem   <= '0;
                            r_state <= S_DIVIDE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo;
                    if (r_iter == LAST_IT) begin
                        r_iter   <= '0;
                        r_rem    <= '0;
                        r_p_out  <= w_p;
                        r_p_last <= (r_idx == LAST_IDX);
                        r_p_vld  <= 1'b1;
                        r_state  <= S_EMIT;
                    end else begin
                        r_iter <= r_iter + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (p_rdy) begin
                        r_p_vld <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_sum   <= '0;
                            r_state <= S_COLLECT;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= S_DIVIDE;
                        end
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

endmodule

// File: doc/softmax_norm.md
SOFTMAX_NORM -- requirements
Module: softmax_norm

Interface
REQ-001 SHALL have parameter ROW_LEN, default 4, the number of e^x entries per row (power of two, 2..16).
REQ-002 SHALL have parameter DIV_CYCLES, default 9, the divider iterations per entry, equal to the quotient width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ex_in  input  9  unsigned e^x value, UQ3.6.
REQ-006 SHALL have port ex_vld  input  1  ex_in valid.
REQ-007 SHALL have port ex_rdy  output  1  block accepts ex_in.
REQ-008 SHALL have port p_out  output  8  normalized probability, UQ0.8.
REQ-009 SHALL have port p_vld  output  1  p_out valid.
REQ-010 SHALL have port p_rdy  input  1  consumer accepts p_out.
REQ-011 SHALL have port p_last  output  1  high with p_vld on the last entry of a row.

Function
REQ-012 SHALL implement states COLLECT, DIVIDE and EMIT; COLLECT is the reset state.
REQ-013 SHALL drive ex_rdy = 1 only in COLLECT (combinational from the state); an ex transfer occurs on an edge where ex_vld & ex_rdy.
REQ-014 SHALL store each accepted ex_in into buffer[idx], add it to an 11-bit unsigned sum (cleared at row start), and increment idx.
REQ-015 SHALL, on the edge accepting entry ROW_LEN-1, enter DIVIDE with idx=0, iteration count=0 and remainder=0.
REQ-016 SHALL compute q = floor(buffer[idx]*256 / sum) in DIVIDE with a restoring divider, one quotient bit per cycle, exactly DIV_CYCLES edges.
REQ-017 SHALL, on the final iteration edge, register p_out = min(q,255) and p_last = (idx==ROW_LEN-1), set p_vld=1, and enter EMIT.
REQ-018 SHALL report p_out=0 for every entry when sum==0 (no divide by zero), with the same timing.
REQ-019 SHALL hold p_out, p_last and p_vld stable in EMIT while p_rdy=0.
REQ-020 SHALL, on the EMIT handshake edge (p_vld & p_rdy), clear p_vld, then either increment idx and enter DIVIDE, or, if idx==ROW_LEN-1, clear idx and sum and enter COLLECT.
REQ-021 SHALL make latency 9 edges from the accepting or handshake edge to the edge at which p_vld rises (DIV_CYCLES=9).
REQ-022 SHALL ignore ex_vld outside COLLECT; input data is never lost or overwritten because ex_rdy=0 there.
REQ-023 SHALL hold p_out at its last value while p_vld=0.
REQ-024 SHALL keep internal widths free of overflow: sum 11 bits (4*511=2044 max), dividend 17 bits, quotient 9 bits before saturation.
REQ-025 SHALL wrap idx from ROW_LEN-1 to 0 only via the transitions in REQ-015 and REQ-020.

Reset
REQ-026 SHALL, when rst_n=0 (immediately, regardless of clk), set state=COLLECT, idx=0, sum=0, iteration count=0, p_vld=0, p_last=0 and p_out=0.
REQ-027 SHALL discard any partial row on reset mid-operation; after release the next accepted ex is entry 0 of a new row.
REQ-028 SHALL NOT require the buffer contents to be reset.

Verification
REQ-029 SHALL cover: row [64,64,64,64], p_rdy=1 -> four outputs p_out=64, p_last only on the 4th, first p_vld 9 edges after the 4th accept.
REQ-030 SHALL cover: row [256,0,0,0] -> p_out=[255 (saturated),0,0,0].
REQ-031 SHALL cover: row [511,511,511,1] -> sum 1534, p_out=[85,85,85,0].
REQ-032 SHALL cover: row [0,0,0,0] -> p_out=[0,0,0,0], no X, same timing.
REQ-033 SHALL cover: p_rdy held low 5 cycles in EMIT -> p_out/p_vld/p_last stable, ex_rdy=0 while ex_vld=1, no extra output.
REQ-034 SHALL cover: two entries accepted, then rst_n pulsed low mid-cycle -> outputs clear at once; next row [64,64,64,64] yields four 64s.
